// File: rtl/spi_adc_scheduler.sv
// spi_adc_scheduler: periodic multi-channel scan of an SPI ADC.
// A period counter produces one frame tick every SAMPLE_PERIOD clocks. Each
// frame walks the channels enabled in ch_mask (latched at frame start) in
// ascending order, runs one SPI transaction per channel through the SPI
// master's start/busy/done handshake and strobes each result out for one cycle.
// Dropped ticks (overrun) and hung transactions (timeout_err) are sticky flags.
//
// Handshake semantics:
//   spi_start is a single-cycle request, asserted only while spi_busy=0; the
//   SPI master accepts it on the edge where spi_start=1. Completion is the
//   single-cycle spi_done pulse, with spi_rx valid in that same cycle; a
//   spi_done outside the waiting state is ignored. sample_valid is a
//   single-cycle strobe with no back-pressure: sample_chan/sample_data are
//   valid with it and hold until the next captured result.
//
// fsm_state exposes the scheduler state: 0=IDLE 1=ISSUE 2=WAIT 3=STORE.
module spi_adc_scheduler #(
  parameter int NCH           = 2,
  parameter int CH_W          = 1,
  parameter int DATA_W        = 10,
  parameter int SAMPLE_PERIOD = 1000,
  parameter int TIMEOUT       = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [NCH-1:0]    ch_mask,
  input  logic              spi_busy,
  input  logic              spi_done,
  input  logic [DATA_W-1:0] spi_rx,
  output logic              spi_start,
  output logic [CH_W-1:0]   spi_chan,
  output logic              sample_valid,
  output logic [CH_W-1:0]   sample_chan,
  output logic [DATA_W-1:0] sample_data,
  output logic              overrun,
  output logic              timeout_err,
  input  logic              err_clr,
  output logic [1:0]        fsm_state
);

  localparam int PCNT_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int WD_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(SAMPLE_PERIOD - 1);
  localparam logic [WD_W-1:0]   WD_LAST   = WD_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    STORE = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [PCNT_W-1:0] pcnt;
  logic [WD_W-1:0]   wd;
  logic [NCH-1:0]    frame_mask;
  logic              tick;
  logic              frame_start;
  logic              timed_out;
  logic              advance;
  logic [CH_W-1:0]   first_idx;
  logic              has_next;
  logic [CH_W-1:0]   next_idx;

  assign tick        = enable && (pcnt == PCNT_LAST);
  assign frame_start = (state == IDLE) && tick && (ch_mask != '0);
  // A hung channel is abandoned on the TIMEOUT-th cycle spent waiting.
  assign timed_out   = (state == WAIT) && !spi_done && (wd == WD_LAST);
  // Moving on to the next channel happens after a stored result or a timeout.
  assign advance     = (state == STORE) || timed_out;

  // Period counter: free-runs while enabled, held at zero while disabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                pcnt <= '0;
    else if (!enable)         pcnt <= '0;
    else if (pcnt == PCNT_LAST) pcnt <= '0;
    else                      pcnt <= pcnt + PCNT_W'(1);
  end

  // Lowest enabled channel in the live mask, used to open a frame.
  always_comb begin
    first_idx = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (ch_mask[i]) first_idx = CH_W'(i);
    end
  end

  // Lowest channel of the frame mask strictly above the current one.
  always_comb begin
    has_next = 1'b0;
    next_idx = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (frame_mask[i] && (CH_W'(i) > spi_chan)) begin
        has_next = 1'b1;
        next_idx = CH_W'(i);
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // FSM next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (frame_start) state_nx = ISSUE;
      ISSUE:   if (!spi_busy) state_nx = WAIT;
      WAIT: begin
        if (spi_done)       state_nx = STORE;
        else if (timed_out) state_nx = has_next ? ISSUE : IDLE;
      end
      STORE:   state_nx = has_next ? ISSUE : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // FSM outputs: start request and result strobe decode straight from state.
  always_comb begin
    spi_start    = (state == ISSUE) && !spi_busy;
    sample_valid = (state == STORE);
    fsm_state    = state;
  end

  // Watchdog: zero outside WAIT, counts cycles spent in WAIT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)              wd <= '0;
    else if (state != WAIT) wd <= '0;
    else                    wd <= wd + WD_W'(1);
  end

  // Frame mask and current channel: latched at frame start, stepped on advance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_mask <= '0;
      spi_chan   <= '0;
    end else if (frame_start) begin
      frame_mask <= ch_mask;
      spi_chan   <= first_idx;
    end else if (advance && has_next) begin
      spi_chan   <= next_idx;
    end
  end

  // Result capture: only a spi_done seen while waiting is taken.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sample_data <= '0;
      sample_chan <= '0;
    end else if ((state == WAIT) && spi_done) begin
      sample_data <= spi_rx;
      sample_chan <= spi_chan;
    end
  end

  // Sticky error flags; a set event in the same cycle as err_clr wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (tick && (state != IDLE)) overrun <= 1'b1;
      else if (err_clr)            overrun <= 1'b0;
      if (timed_out)               timeout_err <= 1'b1;
      else if (err_clr)            timeout_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_adc_scheduler.sv
// Bench for spi_adc_scheduler: directed scenarios, a simple SPI master stand-in
// and a queue-based behavioural model checked against the DUT every cycle.
// Timing within a cycle (period 10, posedge at +5 after each negedge):
//   negedge+1 SPI stand-in drives busy/done/rx
//   negedge+2 main stimulus writes inputs and literal checks
//   negedge+3 compare process checks every output, then steps the model
//   negedge+4 SPI stand-in samples spi_start
module tb_spi_adc_scheduler;

  localparam int NCH    = 2;
  localparam int CH_W   = 1;
  localparam int DATA_W = 10;
  localparam int SP     = 20;
  localparam int TO     = 15;

  localparam int S_IDLE  = 0;
  localparam int S_ISSUE = 1;
  localparam int S_WAIT  = 2;
  localparam int S_STORE = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic              enable = 1'b0;
  logic [NCH-1:0]    ch_mask = '0;
  logic              err_clr = 1'b0;
  logic              spi_busy;
  logic              spi_done;
  logic [DATA_W-1:0] spi_rx;
  logic              spi_start;
  logic [CH_W-1:0]   spi_chan;
  logic              sample_valid;
  logic [CH_W-1:0]   sample_chan;
  logic [DATA_W-1:0] sample_data;
  logic              overrun;
  logic              timeout_err;
  logic [1:0]        fsm_state;

  spi_adc_scheduler #(
    .NCH(NCH), .CH_W(CH_W), .DATA_W(DATA_W), .SAMPLE_PERIOD(SP), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .ch_mask(ch_mask),
    .spi_busy(spi_busy), .spi_done(spi_done), .spi_rx(spi_rx),
    .spi_start(spi_start), .spi_chan(spi_chan),
    .sample_valid(sample_valid), .sample_chan(sample_chan), .sample_data(sample_data),
    .overrun(overrun), .timeout_err(timeout_err), .err_clr(err_clr),
    .fsm_state(fsm_state)
  );

  // ---------------- SPI master stand-in ----------------
  // Busy for 8 cycles after a start, done dev_dly cycles after the start.
  logic              dev_busy = 1'b0;
  logic              dev_done = 1'b0;
  logic [DATA_W-1:0] dev_rx = '0;
  bit                dev_act = 1'b0;
  int                dev_el = 0;
  int                dev_dly = 8;
  bit                dev_done_en = 1'b1;
  logic              force_busy = 1'b0;
  logic              inj_done = 1'b0;
  logic [DATA_W-1:0] inj_rx = '0;
  logic [DATA_W-1:0] rx_tab [NCH];

  assign spi_busy = dev_busy | force_busy;
  assign spi_done = dev_done | inj_done;
  assign spi_rx   = inj_done ? inj_rx : dev_rx;

  always begin
    @(negedge clk);
    #1;
    if (reset) begin
      dev_act  = 1'b0;
      dev_busy = 1'b0;
      dev_done = 1'b0;
    end else if (dev_act) begin
      dev_el++;
      dev_busy = (dev_el <= 8);
      dev_done = dev_done_en && (dev_el == dev_dly);
      if (dev_el >= dev_dly) dev_act = 1'b0;
    end else begin
      dev_busy = 1'b0;
      dev_done = 1'b0;
    end
    #3;
    if (reset) dev_act = 1'b0;
    else if (spi_start === 1'b1) begin
      dev_act = 1'b1;
      dev_el  = 0;
      dev_rx  = rx_tab[spi_chan];
    end
  end

  // ---------------- scoreboard bookkeeping ----------------
  int n_chk = 0;
  int n_pass = 0;
  int n_start = 0;
  int n_valid = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // The frame is a queue of channel numbers; the head is the channel in flight.
  int                m_pcnt;
  int                m_stage;
  int                m_q[$];
  int                m_chan;
  int                m_schan;
  logic [DATA_W-1:0] m_sdata;
  bit                m_ovr;
  bit                m_to;
  int                m_cyc;
  int                m_wstart;

  task automatic model_reset();
    m_pcnt = 0; m_stage = S_IDLE; m_q.delete(); m_chan = 0; m_schan = 0;
    m_sdata = '0; m_ovr = 1'b0; m_to = 1'b0; m_cyc = 0; m_wstart = 0;
  endtask

  task automatic next_channel();
    void'(m_q.pop_front());
    if (m_q.size() > 0) begin
      m_chan  = m_q[0];
      m_stage = S_ISSUE;
    end else begin
      m_stage = S_IDLE;
    end
  endtask

  task automatic model_step();
    bit tick;
    bit set_ovr;
    bit set_to;
    tick    = enable && (m_pcnt == SP - 1);
    set_ovr = tick && (m_stage != S_IDLE);
    set_to  = 1'b0;
    case (m_stage)
      S_IDLE: begin
        if (tick && (ch_mask != '0)) begin
          m_q.delete();
          for (int i = 0; i < NCH; i++) if (ch_mask[i]) m_q.push_back(i);
          m_chan  = m_q[0];
          m_stage = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!spi_busy) begin
          m_stage  = S_WAIT;
          m_wstart = m_cyc + 1;
        end
      end
      S_WAIT: begin
        if (spi_done) begin
          m_sdata = spi_rx;
          m_schan = m_chan;
          m_stage = S_STORE;
        end else if (m_cyc - m_wstart + 1 >= TO) begin
          set_to = 1'b1;
          next_channel();
        end
      end
      default: next_channel();
    endcase
    m_ovr  = set_ovr ? 1'b1 : (err_clr ? 1'b0 : m_ovr);
    m_to   = set_to  ? 1'b1 : (err_clr ? 1'b0 : m_to);
    m_pcnt = enable ? (m_pcnt + 1) % SP : 0;
    m_cyc++;
  endtask

  // ---------------- compare process ----------------
  always begin
    @(negedge clk);
    #3;
    if (spi_start === 1'b1) n_start++;
    if (sample_valid === 1'b1) n_valid++;
    if (reset) begin
      model_reset();
      chk("rst_spi_start", spi_start, 0);
      chk("rst_spi_chan", spi_chan, 0);
      chk("rst_sample_valid", sample_valid, 0);
      chk("rst_sample_chan", sample_chan, 0);
      chk("rst_sample_data", sample_data, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_timeout_err", timeout_err, 0);
      chk("rst_fsm_state", fsm_state, S_IDLE);
    end else begin
      chk("spi_start", spi_start, ((m_stage == S_ISSUE) && !spi_busy) ? 1 : 0);
      chk("spi_chan", spi_chan, m_chan);
      chk("sample_valid", sample_valid, (m_stage == S_STORE) ? 1 : 0);
      chk("sample_chan", sample_chan, m_schan);
      chk("sample_data", sample_data, m_sdata);
      chk("overrun", overrun, m_ovr);
      chk("timeout_err", timeout_err, m_to);
      chk("fsm_state", fsm_state, m_stage);
      model_step();
    end
  end

  // ---------------- driver tasks ----------------
  int cyc = 0;

  task automatic nxt();
    @(negedge clk);
    #2;
  endtask

  task automatic to_cyc(input int c);
    while (cyc < c) begin
      nxt();
      cyc++;
    end
  endtask

  task automatic reset_dut();
    reset = 1'b1; enable = 1'b0; ch_mask = '0; err_clr = 1'b0;
    force_busy = 1'b0; inj_done = 1'b0; dev_dly = 8; dev_done_en = 1'b1;
    nxt();
    nxt();
    chk("lit_reset_state", fsm_state, S_IDLE);
    chk("lit_reset_flags", {overrun, timeout_err, sample_valid, spi_start}, 0);
    reset = 1'b0;
  endtask

  task automatic start_at0(input logic [NCH-1:0] mask);
    nxt();
    enable  = 1'b1;
    ch_mask = mask;
    cyc     = 0;
  endtask

  int s0;
  int v0;

  // ---------------- directed scenarios ----------------
  initial begin
    model_reset();
    rx_tab[0] = 10'h2B5;
    rx_tab[1] = 10'h04A;

    // Two-channel frame.
    reset_dut();
    start_at0(2'b11);
    s0 = n_start;
    to_cyc(19);
    chk("s1_idle_before_tick", fsm_state, S_IDLE);
    to_cyc(20);
    chk("s1_start0", spi_start, 1);
    chk("s1_chan0", spi_chan, 0);
    to_cyc(25);
    enable = 1'b0;
    to_cyc(29);
    chk("s1_valid0", sample_valid, 1);
    chk("s1_schan0", sample_chan, 0);
    chk("s1_data0", sample_data, 10'h2B5);
    to_cyc(30);
    chk("s1_start1", spi_start, 1);
    chk("s1_chan1", spi_chan, 1);
    to_cyc(39);
    chk("s1_valid1", sample_valid, 1);
    chk("s1_schan1", sample_chan, 1);
    chk("s1_data1", sample_data, 10'h04A);
    to_cyc(40);
    chk("s1_back_idle", fsm_state, S_IDLE);
    chk("s1_hold_data", sample_data, 10'h04A);
    to_cyc(60);
    chk("s1_start_count", n_start - s0, 2);

    // Sparse mask with a busy stall of 5 cycles after the tick.
    reset_dut();
    rx_tab[1] = 10'h155;
    start_at0(2'b10);
    s0 = n_start;
    v0 = n_valid;
    to_cyc(19);
    force_busy = 1'b1;
    for (int c = 20; c <= 24; c++) begin
      to_cyc(c);
      chk("s2_stall_start", spi_start, 0);
      chk("s2_stall_state", fsm_state, S_ISSUE);
    end
    to_cyc(25);
    force_busy = 1'b0;
    #1;
    chk("s2_start", spi_start, 1);
    chk("s2_chan", spi_chan, 1);
    to_cyc(30);
    enable = 1'b0;
    to_cyc(34);
    chk("s2_valid", sample_valid, 1);
    chk("s2_schan", sample_chan, 1);
    chk("s2_data", sample_data, 10'h155);
    to_cyc(45);
    chk("s2_one_start", n_start - s0, 1);
    chk("s2_one_valid", n_valid - v0, 1);

    // Overrun: done 30 cycles after start; the 15-cycle watchdog ends ch0,
    // so the tick at cycle 39 lands while ch1 is waiting.
    reset_dut();
    dev_dly = 30;
    start_at0(2'b11);
    v0 = n_valid;
    to_cyc(35);
    chk("s3_no_to_yet", timeout_err, 0);
    to_cyc(36);
    chk("s3_to_ch0", timeout_err, 1);
    chk("s3_start_ch1", spi_start, 1);
    chk("s3_chan_ch1", spi_chan, 1);
    to_cyc(39);
    err_clr = 1'b1;
    to_cyc(40);
    err_clr = 1'b0;
    chk("s3_overrun_set_wins", overrun, 1);
    chk("s3_to_cleared", timeout_err, 0);
    chk("s3_no_new_frame", fsm_state, S_WAIT);
    to_cyc(45);
    enable = 1'b0;
    chk("s3_overrun_sticky", overrun, 1);
    to_cyc(52);
    chk("s3_to_ch1", timeout_err, 1);
    chk("s3_idle", fsm_state, S_IDLE);
    chk("s3_no_valid", n_valid - v0, 0);
    to_cyc(55);
    err_clr = 1'b1;
    to_cyc(56);
    err_clr = 1'b0;
    chk("s3_overrun_clr", overrun, 0);
    chk("s3_to_clr", timeout_err, 0);

    // Timeout: spi_done never arrives.
    reset_dut();
    dev_done_en = 1'b0;
    start_at0(2'b11);
    v0 = n_valid;
    to_cyc(22);
    enable = 1'b0;
    to_cyc(35);
    chk("s4_before_to", timeout_err, 0);
    to_cyc(36);
    chk("s4_to", timeout_err, 1);
    chk("s4_ch1_start", spi_start, 1);
    chk("s4_ch1_chan", spi_chan, 1);
    to_cyc(52);
    chk("s4_idle", fsm_state, S_IDLE);
    chk("s4_no_valid", n_valid - v0, 0);
    chk("s4_no_overrun", overrun, 0);

    // Disable mid-frame, then asynchronous reset while waiting.
    reset_dut();
    rx_tab[1] = 10'h04A;
    start_at0(2'b11);
    s0 = n_start;
    to_cyc(22);
    enable = 1'b0;
    to_cyc(29);
    chk("s5_data0", sample_data, 10'h2B5);
    to_cyc(39);
    chk("s5_data1", sample_data, 10'h04A);
    to_cyc(80);
    chk("s5_no_more_start", n_start - s0, 2);
    enable = 1'b1;
    to_cyc(103);
    chk("s5_in_wait", fsm_state, S_WAIT);
    reset = 1'b1;
    #1;
    chk("s5_async_state", fsm_state, S_IDLE);
    chk("s5_async_outs", {spi_start, spi_chan, sample_valid, sample_chan, overrun, timeout_err}, 0);
    chk("s5_async_data", sample_data, 0);
    to_cyc(105);
    reset = 1'b0;
    enable = 1'b0;
    to_cyc(107);
    inj_rx = 10'h3FF;
    inj_done = 1'b1;
    to_cyc(108);
    inj_done = 1'b0;
    chk("s5_stale_valid", sample_valid, 0);
    chk("s5_stale_data", sample_data, 0);
    chk("s5_stale_state", fsm_state, S_IDLE);
    to_cyc(112);
    chk("s5_stale_hold", sample_data, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/spi_adc_scheduler.md
Name: spi_adc_scheduler

Overview:
Sequences periodic conversions on a multi-channel SPI ADC by driving the existing SPI master core through its start/busy/done handshake. Every SAMPLE_PERIOD clocks it starts a frame that scans all enabled channels in ascending order. For each channel it issues one SPI transaction and publishes the result as a one-cycle valid pulse toward the LED/display logic. It also flags overruns and hung transactions.

Parameters:
NCH, 2, number of ADC channels (>=1)
CH_W, 1, channel index width, ceil(log2(NCH)) with a minimum of 1
DATA_W, 10, ADC result width
SAMPLE_PERIOD, 1000, clocks between frame ticks (>=2)
TIMEOUT, 255, maximum clocks to wait for spi_done

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
enable  in  1  allows frame ticks
ch_mask  in  NCH  channel enable mask, sampled at frame start
spi_busy  in  1  SPI master busy
spi_done  in  1  one-cycle pulse: transaction complete, spi_rx valid
spi_rx  in  DATA_W  received conversion result
spi_start  out  1  one-cycle request to the SPI master
spi_chan  out  CH_W  channel to encode in the command word
sample_valid  out  1  one-cycle result strobe
sample_chan  out  CH_W  channel of the current result
sample_data  out  DATA_W  current result
overrun  out  1  sticky: a tick was dropped
timeout_err  out  1  sticky: spi_done was not seen within TIMEOUT
err_clr  in  1  clears overrun and timeout_err

Behaviour:
- Reset: all outputs 0, FSM in IDLE, period counter 0, frame mask 0. Reset is asynchronous and may occur mid-transaction; the SPI master is reset by the same signal.
- Period counter: increments every cycle while enable=1 and wraps at SAMPLE_PERIOD-1. tick=1 in the cycle the counter equals SAMPLE_PERIOD-1. While enable=0 the counter is forced to 0 and no ticks occur. A frame already in progress runs to completion.
- FSM states: IDLE, ISSUE, WAIT, STORE.
- IDLE:
  - On tick with ch_mask≠0: latch ch_mask into the frame mask, set spi_chan to the lowest set bit, go to ISSUE on the next edge.
  - On tick with ch_mask=0: nothing happens and overrun is not set.
- ISSUE:
  - spi_start = 1 in every ISSUE cycle where spi_busy=0 (combinational from state and spi_busy). The FSM goes to WAIT on the following edge.
  - If spi_busy=1, stay in ISSUE with spi_start=0.
- WAIT:
  - A watchdog counter starts at 0 on entry and increments each cycle.
  - On spi_done=1: register sample_data<=spi_rx and sample_chan<=spi_chan, go to STORE.
  - If the watchdog reaches TIMEOUT without spi_done: set timeout_err, drop the channel (no sample_valid), and proceed as from STORE.
  - A spi_done arriving while not in WAIT is ignored.
- STORE: sample_valid=1 for exactly this one cycle. Then:
  - If the frame mask has a set bit above spi_chan: load that index into spi_chan and go to ISSUE.
  - Otherwise go to IDLE.
- Latency:
  - Tick edge to spi_start: 1 cycle, when spi_busy=0.
  - spi_done to sample_valid: 1 cycle.
  - STORE to the next spi_start: 1 cycle.
- sample_data and sample_chan hold their values until the next spi_done captured in WAIT.
- Overrun: a tick seen in any state other than IDLE sets overrun and is discarded; the current frame is unaffected.
- Flag priority: if err_clr and a set event occur in the same cycle, set wins.
- ch_mask changes mid-frame have no effect until the next frame.
- Channel order is strictly ascending within a frame; there is no wrap-around within a frame.

Test Plan:
- Bench setup for all scenarios: SAMPLE_PERIOD=20, NCH=2, TIMEOUT=15, SPI model with busy for 8 cycles and done 8 cycles after start.
- Two-channel frame: reset, enable=1, ch_mask=2'b11, model returns 10'h2B5 for ch0 and 10'h04A for ch1. Required: spi_start at cycle 20 with spi_chan=0; sample_valid with chan 0 / data 10'h2B5; spi_start with spi_chan=1 one cycle after that valid; sample_valid with chan 1 / data 10'h04A; FSM returns to IDLE.
- Sparse mask and busy stall: ch_mask=2'b10 with spi_busy held 1 for 5 cycles after the tick. Required: spi_start held off for those 5 cycles, then exactly one start with spi_chan=1; exactly one sample_valid per frame.
- Overrun: model done delay of 30 cycles so the next tick lands in WAIT. Required: overrun=1 and stays 1; that tick starts no new frame; err_clr=1 returns overrun to 0.
- Timeout: model never pulses spi_done. Required: timeout_err=1 after 15 WAIT cycles; no sample_valid for ch0; ch1 is still issued in the same frame.
- Disable and async reset: drop enable mid-frame. Required: the frame completes and no further spi_start occurs. Then assert reset in WAIT. Required: all outputs 0 immediately and FSM in IDLE, with a stale spi_done afterward ignored.
